// File: rtl/pipelined_bk_adder.sv
// Streamed Brent-Kung adder/subtractor with selectable pipeline depth.
// Latency is PIPE+1 cycles. A single global stall signal, derived from the output handshake, freezes every stage.
module pipelined_bk_adder #(
  parameter int WIDTH = 11,
  parameter int PIPE  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH:0]   S,
  output logic             OVF
);

  localparam int LOG = $clog2(WIDTH);

  logic             advance;
  logic [WIDTH-1:0] yPrime;
  logic             c0In;

  assign advance  = OUT_READY | ~OUT_VALID;
  assign IN_READY = advance;
  assign yPrime   = SUB ? ~Y : Y;
  assign c0In     = SUB | CIN;

  logic [WIDTH-1:0] aX;
  logic [WIDTH-1:0] aY;
  logic             aC0;
  logic             aValid;

  generate
    if (PIPE >= 1) begin : gInReg
      logic [WIDTH-1:0] opX_q;
      logic [WIDTH-1:0] opY_q;
      logic             opC0_q;
      logic             opValid_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          opX_q     <= '0;
          opY_q     <= '0;
          opC0_q    <= 1'b0;
          opValid_q <= 1'b0;
        end else if (advance) begin
          opX_q     <= X;
          opY_q     <= yPrime;
          opC0_q    <= c0In;
          opValid_q <= IN_VALID;
        end
      end

      assign aX     = opX_q;
      assign aY     = opY_q;
      assign aC0    = opC0_q;
      assign aValid = opValid_q;
    end else begin : gInComb
      assign aX     = X;
      assign aY     = yPrime;
      assign aC0    = c0In;
      assign aValid = IN_VALID;
    end
  endgenerate

  // Up-sweep: node i combines with node i-2^lv when i+1 is a multiple of 2^(lv+1).
  logic [LOG:0][WIDTH-1:0] upG;
  logic [LOG:0][WIDTH-1:0] upP;

  assign upG[0] = aX & aY;
  assign upP[0] = aX ^ aY;

  generate
    for (genvar lv = 0; lv < LOG; lv++) begin : gUpLevel
      for (genvar i = 0; i < WIDTH; i++) begin : gUpNode
        if (((i + 1) % (1 << (lv + 1))) == 0) begin : gOp
          assign upG[lv+1][i] = upG[lv][i] | (upP[lv][i] & upG[lv][i-(1<<lv)]);
          assign upP[lv+1][i] = upP[lv][i] & upP[lv][i-(1<<lv)];
        end else begin : gPass
          assign upG[lv+1][i] = upG[lv][i];
          assign upP[lv+1][i] = upP[lv][i];
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] bG;
  logic [WIDTH-1:0] bP;
  logic [WIDTH-1:0] bBitP;
  logic             bC0;
  logic             bValid;

  generate
    if (PIPE == 2) begin : gMidReg
      logic [WIDTH-1:0] treeG_q;
      logic [WIDTH-1:0] treeP_q;
      logic [WIDTH-1:0] bitP_q;
      logic             midC0_q;
      logic             midValid_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          treeG_q    <= '0;
          treeP_q    <= '0;
          bitP_q     <= '0;
          midC0_q    <= 1'b0;
          midValid_q <= 1'b0;
        end else if (advance) begin
          treeG_q    <= upG[LOG];
          treeP_q    <= upP[LOG];
          bitP_q     <= upP[0];
          midC0_q    <= aC0;
          midValid_q <= aValid;
        end
      end

      assign bG     = treeG_q;
      assign bP     = treeP_q;
      assign bBitP  = bitP_q;
      assign bC0    = midC0_q;
      assign bValid = midValid_q;
    end else begin : gMidComb
      assign bG     = upG[LOG];
      assign bP     = upP[LOG];
      assign bBitP  = upP[0];
      assign bC0    = aC0;
      assign bValid = aValid;
    end
  endgenerate

  // Down-sweep fills the remaining prefixes from the complete prefix at i-2^lv.
  logic [LOG-1:0][WIDTH-1:0] dnG;
  logic [LOG-1:0][WIDTH-1:0] dnP;

  assign dnG[LOG-1] = bG;
  assign dnP[LOG-1] = bP;

  generate
    for (genvar lv = 0; lv < LOG - 1; lv++) begin : gDnLevel
      for (genvar i = 0; i < WIDTH; i++) begin : gDnNode
        if ((((i + 1) % (1 << (lv + 1))) == (1 << lv)) && ((i + 1) > (1 << (lv + 1)))) begin : gOp
          assign dnG[lv][i] = dnG[lv+1][i] | (dnP[lv+1][i] & dnG[lv+1][i-(1<<lv)]);
          assign dnP[lv][i] = dnP[lv+1][i] & dnP[lv+1][i-(1<<lv)];
        end else begin : gPass
          assign dnG[lv][i] = dnG[lv+1][i];
          assign dnP[lv][i] = dnP[lv+1][i];
        end
      end
    end
  endgenerate

  logic [WIDTH:0] carry;
  logic [WIDTH:0] sum_d;
  logic           ovf_d;

  assign carry = {dnG[0] | (dnP[0] & {WIDTH{bC0}}), bC0};
  assign sum_d = {carry[WIDTH], bBitP ^ carry[WIDTH-1:0]};
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  logic [WIDTH:0] sum_q;
  logic           ovf_q;
  logic           outValid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_q      <= '0;
      ovf_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else if (advance) begin
      sum_q      <= sum_d;
      ovf_q      <= ovf_d;
      outValid_q <= bValid;
    end
  end

  assign S         = sum_q;
  assign OVF       = ovf_q;
  assign OUT_VALID = outValid_q;

endmodule

// File: tb/tb_pipelined_bk_adder.sv
// Scoreboard bench for pipelined_bk_adder: several lanes with different WIDTH/PIPE settings run in lockstep.
// Every accepted operation is queued, and each lane checks its outputs against a golden model in order.
module tb_pipelined_bk_adder;

  localparam int NL = 7;

  function automatic int laneW(int k);
    case (k)
      0, 1, 2: return 11;
      3:       return 2;
      4:       return 33;
      5:       return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int laneP(int k);
    case (k)
      0, 5:    return 0;
      1, 3, 6: return 1;
      default: return 2;
    endcase
  endfunction

  typedef struct packed {
    logic [63:0] x;
    logic [63:0] y;
    logic        cin;
    logic        sub;
    logic        hasRef;
    logic [11:0] refS;
    logic        refOvf;
  } opT;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          offer = 1'b0;
  logic          outReady = 1'b0;
  logic [63:0]   xDrv = '0;
  logic [63:0]   yDrv = '0;
  logic          cinDrv = 1'b0;
  logic          subDrv = 1'b0;
  logic          laneValid;
  logic [NL-1:0] inReady;
  logic [NL-1:0] outValid;
  logic [NL-1:0] ovf;
  logic [64:0]   sArr [NL];

  opT expList[$];
  int rdIdx [NL];
  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;

  logic trackLat = 1'b0;
  logic bpMode = 1'b0;
  int   trackStart = -1;
  int   firstSeen [NL];
  int   lastSeen [NL];
  int   seenCnt [NL];

  always #5 clock = ~clock;

  assign laneValid = offer & (&inReady);

  for (genvar k = 0; k < NL; k++) begin : gLane
    localparam int LW = laneW(k);
    localparam int LP = laneP(k);
    logic [LW:0] sLane;

    pipelined_bk_adder #(.WIDTH(LW), .PIPE(LP)) uDut (
      .CLK(clock),
      .RST(reset),
      .IN_VALID(laneValid),
      .IN_READY(inReady[k]),
      .X(xDrv[LW-1:0]),
      .Y(yDrv[LW-1:0]),
      .CIN(cinDrv),
      .SUB(subDrv),
      .OUT_VALID(outValid[k]),
      .OUT_READY(outReady),
      .S(sLane),
      .OVF(ovf[k])
    );

    assign sArr[k] = 65'(sLane);
  end

  // Golden result: {ovf, carry, sum} computed with plain arithmetic and a sign-based overflow test.
  function automatic logic [65:0] golden(int w, logic [63:0] x, logic [63:0] y, logic cin, logic sub);
    logic [64:0] mask;
    logic [64:0] xm;
    logic [64:0] ym;
    logic [64:0] sum;
    logic        xs;
    logic        ys;
    logic        rs;
    mask = (65'd1 << w) - 65'd1;
    xm   = {1'b0, x} & mask;
    ym   = {1'b0, (sub ? ~y : y)} & mask;
    sum  = xm + ym + 65'(sub | cin);
    sum  = sum & ((mask << 1) | 65'd1);
    xs   = xm[w-1];
    ys   = ym[w-1];
    rs   = sum[w-1];
    return {(xs == ys) && (rs != xs), sum};
  endfunction

  task automatic checkOutput(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkLane(input int k);
    opT e;
    if (rdIdx[k] >= expList.size()) begin
      checkOutput($sformatf("L%0d_unexpected_output", k), 66'd1, 66'd0);
    end else begin
      e = expList[rdIdx[k]];
      checkOutput($sformatf("L%0d_result_%0d", k, rdIdx[k]), {ovf[k], sArr[k]},
                  golden(laneW(k), e.x, e.y, e.cin, e.sub));
      if (e.hasRef && laneW(k) == 11)
        checkOutput($sformatf("L%0d_ref_%0d", k, rdIdx[k]), 66'({ovf[k], sArr[k][11:0]}),
                    66'({e.refOvf, e.refS}));
      rdIdx[k]++;
    end
  endtask

  // One clock cycle: drive at the falling edge, then sample just after it.
  task automatic applyStimulus(input logic vld, input logic rdy, input logic [63:0] x, input logic [63:0] y,
                               input logic cin, input logic sub, input logic hasRef = 1'b0,
                               input logic [11:0] refS = 12'd0, input logic refOvf = 1'b0);
    opT e;
    @(negedge clock);
    offer    = vld;
    outReady = rdy;
    xDrv     = x;
    yDrv     = y;
    cinDrv   = cin;
    subDrv   = sub;
    #1;
    for (int k = 0; k < NL; k++) begin
      if (bpMode && !rdy) begin
        checkOutput($sformatf("L%0d_bp_in_ready", k), 66'(inReady[k]), 66'd0);
        checkOutput($sformatf("L%0d_bp_out_valid", k), 66'(outValid[k]), 66'd1);
        if (rdIdx[k] < expList.size()) begin
          e = expList[rdIdx[k]];
          checkOutput($sformatf("L%0d_bp_hold", k), {ovf[k], sArr[k]},
                      golden(laneW(k), e.x, e.y, e.cin, e.sub));
        end
      end
      if (trackLat && outValid[k]) begin
        if (firstSeen[k] < 0) firstSeen[k] = cyc;
        lastSeen[k] = cyc;
        seenCnt[k]++;
      end
      if (outValid[k] && rdy) checkLane(k);
    end
    if (laneValid) begin
      e = '{x: x, y: y, cin: cin, sub: sub, hasRef: hasRef, refS: refS, refOvf: refOvf};
      expList.push_back(e);
      if (trackLat && trackStart < 0) trackStart = cyc;
    end
    cyc++;
  endtask

  task automatic resetDut();
    @(negedge clock);
    reset    = 1'b1;
    offer    = 1'b0;
    outReady = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int k = 0; k < NL; k++) begin
      checkOutput($sformatf("L%0d_rst_out_valid", k), 66'(outValid[k]), 66'd0);
      checkOutput($sformatf("L%0d_rst_in_ready", k), 66'(inReady[k]), 66'd1);
      rdIdx[k] = expList.size();
    end
  endtask

  task automatic drainCheck(input string tag);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < NL; k++)
      checkOutput($sformatf("L%0d_%s_drained", k, tag), 66'(rdIdx[k]), 66'(expList.size()));
  endtask

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 64'h5555_5555_5555_5555;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < NL; k++) rdIdx[k] = 0;
    resetDut();

    // Overflow and borrow corner cases, with fixed 11-bit reference values.
    applyStimulus(1'b1, 1'b1, 64'h7FF, 64'h001, 1'b0, 1'b0, 1'b1, 12'h800, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h3FF, 64'h001, 1'b0, 1'b0, 1'b1, 12'h400, 1'b1);
    applyStimulus(1'b1, 1'b1, 64'h005, 64'h007, 1'b0, 1'b1, 1'b1, 12'h7FE, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h400, 64'h001, 1'b0, 1'b1, 1'b1, 12'hBFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 64'h7FF, 64'h7FF, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0);
    applyStimulus(1'b1, 1'b1, 64'h123, 64'h0F0, 1'b1, 1'b1, 1'b1, 12'h833, 1'b0);
    drainCheck("directed");

    // Throughput: 16 back-to-back operations into an empty pipe.
    for (int k = 0; k < NL; k++) begin
      firstSeen[k] = -1;
      lastSeen[k]  = -1;
      seenCnt[k]   = 0;
    end
    trackStart = -1;
    trackLat   = 1'b1;
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, randOperand(), randOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);
    trackLat = 1'b0;
    for (int k = 0; k < NL; k++) begin
      checkOutput($sformatf("L%0d_latency", k), 66'(firstSeen[k] - trackStart), 66'(laneP(k) + 1));
      checkOutput($sformatf("L%0d_burst_span", k), 66'(lastSeen[k] - firstSeen[k] + 1), 66'd16);
      checkOutput($sformatf("L%0d_burst_count", k), 66'(seenCnt[k]), 66'd16);
    end
    drainCheck("burst");

    // Backpressure: fill the pipes, stall the output for five cycles, then release.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, randOperand(), randOperand(), 1'b0, 1'($urandom_range(0, 1)));
    bpMode = 1'b1;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b0, randOperand(), randOperand(), 1'b1, 1'b0);
    bpMode = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, randOperand(), randOperand(), 1'b1, 1'b0);
    drainCheck("backpressure");

    // Reset with operations still in flight: nothing stale may come out afterwards.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, randOperand(), randOperand(), 1'b0, 1'b0);
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0);

    // Random traffic with random valid and ready.
    for (int i = 0; i < 3000; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7), randOperand(), randOperand(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drainCheck("random");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
